// File: rtl/bp_pkg.sv
// Shared types and constants for the branch target buffer / direction predictor.
// Combinational definitions only; no latency.
// No flow control; nothing here holds state.
package bp_pkg;

    // Widest address the table entry storage is sized for; narrower XLEN zero-extends.
    localparam int BP_XLEN = 32;

    typedef logic [1:0] ctr_t;

    localparam ctr_t SNT       = 2'b00;
    localparam ctr_t WNT       = 2'b01;
    localparam ctr_t WT        = 2'b10;
    localparam ctr_t ST        = 2'b11;
    localparam ctr_t CTR_RESET = WNT;
    localparam ctr_t ALLOC_BR  = WT;
    localparam ctr_t ALLOC_JMP = ST;

    typedef struct packed {
        logic                valid;
        logic [BP_XLEN-1:0]  tag;
        logic [BP_XLEN-1:0]  target;
        ctr_t                ctr;
    } entry_t;

    // The MSB of a 2-bit counter is the taken/not-taken decision.
    function automatic logic ctr_predicts_taken(input ctr_t ctr);
        return ctr[1];
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-lookup and EX-update bundle between the pipeline and the branch predictor.
// Lookup is combinational, update takes effect at the next clock edge.
// No backpressure: EX presents each resolved instruction exactly once.
interface branch_predictor_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] f_pc;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
    logic            u_valid;
    logic [XLEN-1:0] u_pc;
    logic            u_taken;
    logic [XLEN-1:0] u_target;
    logic            u_is_jump;
    logic            u_mispredict;
    logic            inv_all;

    modport master (
        output f_pc, u_valid, u_pc, u_taken, u_target, u_is_jump, u_mispredict, inv_all,
        input  pred_taken, pred_target
    );

    modport slave (
        input  f_pc, u_valid, u_pc, u_taken, u_target, u_is_jump, u_mispredict, inv_all,
        output pred_taken, pred_target
    );
endinterface

// File: rtl/bp_sat_ctr.sv
// 2-bit saturating counter next-state: +1 on taken, -1 on not-taken, force to ST for jumps.
// Purely combinational, zero latency.
// No flow control.
module bp_sat_ctr
    import bp_pkg::*;
(
    input  ctr_t ctr_i,
    input  logic taken_i,
    input  logic force_st_i,
    output ctr_t ctr_o
);

    // Saturate at both ends; jumps are always strongly taken.
    always_comb begin
        ctr_o = ctr_i;
        if (force_st_i) begin
            ctr_o = ST;
        end else if (taken_i) begin
            if (ctr_i != ST) ctr_o = ctr_i + 2'd1;
        end else begin
            if (ctr_i != SNT) ctr_o = ctr_i - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters; optional stats under BP_STATS_EN.
// Lookup 0 cycles (from flopped table, no bypass); update visible the cycle after u_valid.
// No backpressure: one update accepted per cycle, inv_all drops a coincident update.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 64
) (
    input  logic               clk,
    input  logic               rst,
    branch_predictor_if.slave  bp
`ifdef BP_STATS_EN
    ,
    output logic [31:0]        stat_updates,
    output logic [31:0]        stat_mispredicts
`endif
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    entry_t             tbl_q [ENTRIES];
    entry_t             upd_entry_d;
    logic               upd_we;

    logic [IDX_W-1:0]   f_idx;
    logic [BP_XLEN-1:0] f_tag;
    logic               f_hit;
    logic               f_taken;

    logic [IDX_W-1:0]   u_idx;
    logic [BP_XLEN-1:0] u_tag;
    logic [BP_XLEN-1:0] u_tgt;
    logic               u_hit;
    ctr_t               ctr_nxt;

    // Low PC bits never select an entry; they only matter for fetch's +4.
    logic               unused_pc_bits;
    assign unused_pc_bits = ^bp.u_pc[1:0];

    assign f_idx = bp.f_pc[IDX_W+1:2];
    assign f_tag = BP_XLEN'(bp.f_pc[XLEN-1:IDX_W+2]);
    assign u_idx = bp.u_pc[IDX_W+1:2];
    assign u_tag = BP_XLEN'(bp.u_pc[XLEN-1:IDX_W+2]);
    assign u_tgt = BP_XLEN'(bp.u_target);

    // Lookup sees only the registered table, so a same-cycle update is not forwarded.
    always_comb begin
        f_hit          = tbl_q[f_idx].valid && (tbl_q[f_idx].tag == f_tag);
        f_taken        = f_hit && ctr_predicts_taken(tbl_q[f_idx].ctr);
        bp.pred_taken  = f_taken;
        bp.pred_target = f_taken ? tbl_q[f_idx].target[XLEN-1:0] : bp.f_pc + XLEN'(4);
    end

    assign u_hit = tbl_q[u_idx].valid && (tbl_q[u_idx].tag == u_tag);

    bp_sat_ctr u_sat_ctr (
        .ctr_i      (tbl_q[u_idx].ctr),
        .taken_i    (bp.u_taken),
        .force_st_i (bp.u_is_jump),
        .ctr_o      (ctr_nxt)
    );

    // Build the entry to write: train on a hit, allocate only on a taken miss.
    always_comb begin
        upd_we      = 1'b0;
        upd_entry_d = tbl_q[u_idx];
        if (bp.u_valid && !bp.inv_all) begin
            if (u_hit) begin
                upd_we          = 1'b1;
                upd_entry_d.ctr = ctr_nxt;
                if (bp.u_taken || bp.u_is_jump) upd_entry_d.target = u_tgt;
            end else if (bp.u_taken) begin
                upd_we             = 1'b1;
                upd_entry_d.valid  = 1'b1;
                upd_entry_d.tag    = u_tag;
                upd_entry_d.target = u_tgt;
                upd_entry_d.ctr    = bp.u_is_jump ? ALLOC_JMP : ALLOC_BR;
            end
        end
    end

    // Table state: reset to weakly-not-taken invalid entries, invalidate wins over update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_RESET};
            end
        end else if (bp.inv_all) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl_q[i].valid <= 1'b0;
            end
        end else if (upd_we) begin
            tbl_q[u_idx] <= upd_entry_d;
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] stat_updates_q, stat_updates_d;
    logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

    // Saturating event counters; accepted updates exclude those dropped by inv_all.
    always_comb begin
        stat_updates_d     = stat_updates_q;
        stat_mispredicts_d = stat_mispredicts_q;
        if (bp.u_valid && !bp.inv_all && (stat_updates_q != 32'hFFFF_FFFF))
            stat_updates_d = stat_updates_q + 32'd1;
        if (bp.u_valid && bp.u_mispredict && (stat_mispredicts_q != 32'hFFFF_FFFF))
            stat_mispredicts_d = stat_mispredicts_q + 32'd1;
    end

    // Counters clear only on reset, never on inv_all.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_updates_q     <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            stat_updates_q     <= stat_updates_d;
            stat_mispredicts_q <= stat_mispredicts_d;
        end
    end

    assign stat_updates     = stat_updates_q;
    assign stat_mispredicts = stat_mispredicts_q;
`else
    logic unused_mispredict;
    assign unused_mispredict = bp.u_mispredict;
`endif

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised branch target buffer with 2-bit saturating-counter direction prediction for the pipelined RV32I core.
- Sits beside the fetch stage:
  - IF looks up the current PC and gets a predicted next PC in the same cycle.
  - EX writes back resolved branch/jump outcomes one update per cycle.
- Replaces the fixed "predict not-taken, flush on taken" behaviour of the current pipeline with learned, per-entry prediction.

Parameters:
- XLEN, 32, address/data width.
- ENTRIES, 64, table depth; power of two, 4..1024.
- IDX_W, $clog2(ENTRIES), index width (derived, not overridable).
- TAG_W, XLEN-IDX_W-2, tag width (derived).

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- f_pc  in  XLEN  fetch PC to predict.
- pred_taken  out  1  prediction: redirect fetch.
- pred_target  out  XLEN  predicted next PC.
- u_valid  in  1  update strobe from EX (resolved control-flow instruction).
- u_pc  in  XLEN  PC of resolved instruction.
- u_taken  in  1  actual outcome.
- u_target  in  XLEN  actual target.
- u_is_jump  in  1  1 = JAL/JALR (unconditional).
- u_mispredict  in  1  EX detected misprediction (used only by the optional feature).
- inv_all  in  1  synchronous invalidate of whole table (fence.i).

Behaviour:
- Address split:
  - idx = pc[IDX_W+1:2]
  - tag = pc[XLEN-1:IDX_W+2]
  - pc[1:0] ignored.
- Entry fields: valid, tag[TAG_W], target[XLEN], ctr[2].
- Lookup (combinational from flopped table, 0-cycle latency):
  - hit = valid[idx] && tag[idx]==tag(f_pc).
  - pred_taken = hit && ctr[idx][1].
  - pred_target = pred_taken ? target[idx] : f_pc+4. Add wraps modulo 2^XLEN.
- Update (registered on clk rising edge when u_valid):
  - Hit, branch: ctr saturating +1 if u_taken, −1 if not; stays in 00..11. target <= u_target only if u_taken.
  - Hit, jump: ctr <= 11; target <= u_target.
  - Miss, u_taken=1: allocate/overwrite entry. valid=1, tag, target=u_target. ctr = 11 if u_is_jump, else 10.
  - Miss, u_taken=0: no allocation; table unchanged.
- Same-cycle lookup and update to same idx: lookup returns pre-update contents (no bypass). New value is visible the next cycle.
- inv_all: all valid <= 0 at next edge; ctr/target/tag are don't-care. inv_all with u_valid in the same cycle: inv_all wins, the update is dropped.
- Reset (rst=0, asynchronous):
  - all valid=0, all ctr=01.
  - Hence pred_taken=0 and pred_target=f_pc+4 immediately.
  - Reset mid-update discards the update.
- No stall input: EX must present each resolved instruction exactly once.

Optional Feature:
- Macro: BP_STATS_EN.
- Defined:
  - Adds outputs stat_updates[32] and stat_mispredicts[32].
  - stat_updates increments on every accepted u_valid (not dropped by inv_all).
  - stat_mispredicts increments on u_valid && u_mispredict.
  - Both saturate at 32'hFFFF_FFFF, reset to 0, and are unaffected by inv_all.
- Undefined: ports and counters absent; prediction behaviour identical.

Decomposition:
- Package bp_pkg:
  - counter encodings SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11.
  - CTR_RESET=WNT.
  - ALLOC_BR=WT, ALLOC_JMP=ST.
  - entry struct typedef (valid, tag, target, ctr).
- Sub-module bp_sat_ctr: combinational 2-bit saturating next-state (inputs ctr, taken, force_st).

Test Plan:
- Reset, f_pc=0x100 -> pred_taken=0, pred_target=0x104. Stats (if enabled) = 0.
- Branch at 0x200 taken to 0x180: one update, then lookup 0x200 -> pred_taken=1, target=0x180. Two not-taken updates -> pred_taken=0, target=0x204 (ctr 10→01→00). Third not-taken -> ctr stays 00.
- Alias, ENTRIES=64: update 0x200 taken→0x180, then lookup 0x300 (same idx, different tag) -> miss, pred_target=0x304. Taken update at 0x300→0x400 evicts; lookup 0x200 -> miss.
- JAL at 0x40 target 0x800: single update -> ctr=11, pred_taken=1. Lookup in same cycle as the update -> pred_taken=0 (no bypass); next cycle -> 1.
- inv_all and u_valid (0x500 taken) in the same cycle -> every lookup misses afterwards, including 0x500. stat_updates unchanged.
- BP_STATS_EN: 3 updates, one with u_mispredict=1 -> stat_updates=3, stat_mispredicts=1. Preload stat_updates=32'hFFFF_FFFF via force, one more update -> holds at 32'hFFFF_FFFF.
